// File: rtl/cc_psr_condition_unit.sv
// Processor status register and branch-condition evaluator fed by the ALU's active-low flags.
// Answers branch requests through a request/response handshake and tracks overflow events.
//
// state | meaning
// IDLE  | ready for a branch request; reqReady high
// EVAL  | condition code latched; PSR value this cycle decides the branch
// RESP  | taken registered and held with respValid until respReady
module cc_psr_condition_unit #(
  parameter int DATAWIDTH_CONDITION = 4,
  parameter int DATAWIDTH_OVFCOUNT  = 8
) (
  input  logic                          CC_PSR_CLOCK_50,
  input  logic                          CC_PSR_RESET_InLow,
  input  logic                          CC_PSR_overflow_InLow,
  input  logic                          CC_PSR_carry_InLow,
  input  logic                          CC_PSR_negative_InLow,
  input  logic                          CC_PSR_zero_InLow,
  input  logic                          CC_PSR_SetCode_In,
  input  logic [DATAWIDTH_CONDITION-1:0] CC_PSR_condition_InBus,
  input  logic                          CC_PSR_reqValid_In,
  output logic                          CC_PSR_reqReady_Out,
  output logic                          CC_PSR_respValid_Out,
  input  logic                          CC_PSR_respReady_In,
  output logic                          CC_PSR_taken_Out,
  output logic [3:0]                    CC_PSR_flags_OutBus,
  output logic                          CC_PSR_stickyOvf_Out,
  input  logic                          CC_PSR_ovfClear_In,
  output logic [DATAWIDTH_OVFCOUNT-1:0]  CC_PSR_ovfCount_OutBus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT                          state;
  logic [DATAWIDTH_CONDITION-1:0] condLatch;
  logic [3:0]                     psrFlags;
  logic                           stickyOvf;
  logic [DATAWIDTH_OVFCOUNT-1:0]  ovfCount;
  logic                           ovfEvent;

  // The upper condition bit inverts the sense of the lower eight tests.
  function automatic logic condMet(input logic [DATAWIDTH_CONDITION-1:0] sel,
                                   input logic [3:0] f);
    logic n, z, v, c, base;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (sel[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      default: base = v;
    endcase
    return base ^ sel[3];
  endfunction

  assign ovfEvent = CC_PSR_SetCode_In & ~CC_PSR_overflow_InLow;

  always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
    if (!CC_PSR_RESET_InLow) begin
      psrFlags <= 4'b0000;
    end else if (CC_PSR_SetCode_In) begin
      psrFlags <= {~CC_PSR_negative_InLow, ~CC_PSR_zero_InLow,
                   ~CC_PSR_overflow_InLow, ~CC_PSR_carry_InLow};
    end
  end

  // Clear outranks a coincident overflow event; the counter parks at all-ones.
  always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
    if (!CC_PSR_RESET_InLow) begin
      stickyOvf <= 1'b0;
      ovfCount  <= '0;
    end else if (CC_PSR_ovfClear_In) begin
      stickyOvf <= 1'b0;
      ovfCount  <= '0;
    end else if (ovfEvent) begin
      stickyOvf <= 1'b1;
      if (ovfCount != {DATAWIDTH_OVFCOUNT{1'b1}})
        ovfCount <= ovfCount + DATAWIDTH_OVFCOUNT'(1);
    end
  end

  always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
    if (!CC_PSR_RESET_InLow) begin
      state                <= IDLE;
      condLatch            <= '0;
      CC_PSR_reqReady_Out  <= 1'b1;
      CC_PSR_respValid_Out <= 1'b0;
      CC_PSR_taken_Out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CC_PSR_reqValid_In) begin
            condLatch           <= CC_PSR_condition_InBus;
            CC_PSR_reqReady_Out <= 1'b0;
            state               <= EVAL;
          end
        end
        EVAL: begin
          CC_PSR_taken_Out     <= condMet(condLatch, psrFlags);
          CC_PSR_respValid_Out <= 1'b1;
          state                <= RESP;
        end
        RESP: begin
          if (CC_PSR_respReady_In) begin
            CC_PSR_respValid_Out <= 1'b0;
            CC_PSR_reqReady_Out  <= 1'b1;
            state                <= IDLE;
          end
        end
        default: begin
          CC_PSR_respValid_Out <= 1'b0;
          CC_PSR_reqReady_Out  <= 1'b1;
          state                <= IDLE;
        end
      endcase
    end
  end

  assign CC_PSR_flags_OutBus    = psrFlags;
  assign CC_PSR_stickyOvf_Out   = stickyOvf;
  assign CC_PSR_ovfCount_OutBus = ovfCount;

endmodule

// File: tb/tb_cc_psr_condition_unit.sv
// Scoreboard bench for cc_psr_condition_unit: expected branch outcomes are queued at request
// time from a table model of the condition codes and compared when respValid appears.
module tb_cc_psr_condition_unit;

  logic       clk = 1'b0;
  logic       rstN;
  logic       ovfN, carryN, negN, zeroN;
  logic       setCode;
  logic [3:0] cond;
  logic       reqValid, reqReady, respValid, respReady, taken;
  logic [3:0] flags;
  logic       sticky;
  logic       ovfClear;
  logic [7:0] ovfCount;

  int   errors = 0;
  int   checks = 0;
  bit   expQ[$];
  bit   lastExp;
  logic [3:0] modelFlags = 4'b0000;

  always #5 clk = ~clk;

  cc_psr_condition_unit dut (
    .CC_PSR_CLOCK_50        (clk),
    .CC_PSR_RESET_InLow     (rstN),
    .CC_PSR_overflow_InLow  (ovfN),
    .CC_PSR_carry_InLow     (carryN),
    .CC_PSR_negative_InLow  (negN),
    .CC_PSR_zero_InLow      (zeroN),
    .CC_PSR_SetCode_In      (setCode),
    .CC_PSR_condition_InBus (cond),
    .CC_PSR_reqValid_In     (reqValid),
    .CC_PSR_reqReady_Out    (reqReady),
    .CC_PSR_respValid_Out   (respValid),
    .CC_PSR_respReady_In    (respReady),
    .CC_PSR_taken_Out       (taken),
    .CC_PSR_flags_OutBus    (flags),
    .CC_PSR_stickyOvf_Out   (sticky),
    .CC_PSR_ovfClear_In     (ovfClear),
    .CC_PSR_ovfCount_OutBus (ovfCount)
  );

  function automatic bit refTaken(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'h0: return 1'b0;
      4'h1: return z;
      4'h2: return z | (n ^ v);
      4'h3: return n ^ v;
      4'h4: return cy | z;
      4'h5: return cy;
      4'h6: return n;
      4'h7: return v;
      4'h8: return 1'b1;
      4'h9: return !z;
      4'hA: return !(z | (n ^ v));
      4'hB: return !(n ^ v);
      4'hC: return !(cy | z);
      4'hD: return !cy;
      4'hE: return !n;
      default: return !v;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic driveFlags(input bit n, input bit z, input bit v, input bit c);
    negN = !n; zeroN = !z; ovfN = !v; carryN = !c;
  endtask

  task automatic setFlags(input bit n, input bit z, input bit v, input bit c);
    driveFlags(n, z, v, c);
    setCode = 1'b1;
    tick;
    setCode = 1'b0;
    modelFlags = {n, z, v, c};
    checks++;
    if (flags !== modelFlags) begin
      errors++;
      $display("FAIL psr_load got=%b exp=%b", flags, modelFlags);
    end
  endtask

  // Drives one request for a single edge; the scoreboard entry uses the model PSR
  // as it stands after that edge (a coincident SetCode is already folded in by the caller).
  task automatic issue(input logic [3:0] c);
    expQ.push_back(refTaken(c, modelFlags));
    cond = c;
    reqValid = 1'b1;
    tick;
    reqValid = 1'b0;
    checks++;
    if (respValid !== 1'b0 || reqReady !== 1'b0) begin
      errors++;
      $display("FAIL eval_state respValid=%b reqReady=%b exp 0/0", respValid, reqReady);
    end
  endtask

  task automatic collect(input logic [3:0] c);
    int waited = 0;
    while (respValid !== 1'b1 && waited < 8) begin
      tick;
      waited++;
    end
    checks++;
    if (waited != 1) begin
      errors++;
      $display("FAIL resp_latency cond=%h got=%0d exp=1 extra edges", c, waited);
    end
    lastExp = expQ.pop_front();
    checks++;
    if (respValid !== 1'b1 || taken !== lastExp) begin
      errors++;
      $display("FAIL taken cond=%h flags=%b got=%b valid=%b exp=%b", c, modelFlags, taken, respValid, lastExp);
    end
  endtask

  task automatic releaseResp;
    respReady = 1'b1;
    tick;
    respReady = 1'b0;
    checks++;
    if (respValid !== 1'b0 || reqReady !== 1'b1) begin
      errors++;
      $display("FAIL release respValid=%b reqReady=%b exp 0/1", respValid, reqReady);
    end
  endtask

  task automatic branch(input logic [3:0] c);
    issue(c);
    collect(c);
    releaseResp;
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    driveFlags(0, 0, 0, 0);
    setCode = 0; reqValid = 0; respReady = 0; ovfClear = 0; cond = 4'h0;
    tick; tick;
    #2 rstN = 1'b1;
    tick;
    checks++;
    if (flags !== 4'b0000 || reqReady !== 1'b1 || respValid !== 1'b0 ||
        ovfCount !== 8'd0 || sticky !== 1'b0 || taken !== 1'b0) begin
      errors++;
      $display("FAIL reset flags=%b reqReady=%b respValid=%b count=%0d sticky=%b taken=%b exp 0000/1/0/0/0/0",
               flags, reqReady, respValid, ovfCount, sticky, taken);
    end
  endtask

  task automatic test_zero_branch;
    setFlags(0, 1, 0, 0);
    branch(4'h1);
    branch(4'h9);
  endtask

  task automatic test_signed_compare;
    setFlags(1, 0, 0, 0);
    branch(4'h3);
    setFlags(1, 0, 1, 0);
    branch(4'h3);
    branch(4'hB);
  endtask

  task automatic test_same_cycle_setcode;
    setFlags(0, 0, 0, 0);
    driveFlags(0, 1, 0, 0);
    setCode = 1'b1;
    modelFlags = 4'b0100;
    issue(4'h1);
    setCode = 1'b0;
    collect(4'h1);
    releaseResp;
  endtask

  task automatic test_stall;
    setFlags(0, 1, 0, 0);
    issue(4'h1);
    collect(4'h1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        driveFlags(0, 0, 0, 0);
        setCode = 1'b1;
        modelFlags = 4'b0000;
      end
      tick;
      setCode = 1'b0;
      checks++;
      if (respValid !== 1'b1 || taken !== lastExp || reqReady !== 1'b0) begin
        errors++;
        $display("FAIL stall cyc=%0d respValid=%b taken=%b reqReady=%b exp 1/%b/0", i, respValid, taken, reqReady, lastExp);
      end
    end
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL stall_psr_update got=%b exp=0000", flags);
    end
    releaseResp;
  endtask

  task automatic test_all_conditions;
    logic [3:0] pats [5];
    pats[0] = 4'b0000; pats[1] = 4'b1010; pats[2] = 4'b0101; pats[3] = 4'b1111; pats[4] = 4'b1000;
    for (int p = 0; p < 5; p++) begin
      setFlags(pats[p][3], pats[p][2], pats[p][1], pats[p][0]);
      for (int c = 0; c < 16; c++) branch(4'(c));
    end
  endtask

  task automatic test_saturation;
    ovfClear = 1'b1;
    tick;
    ovfClear = 1'b0;
    checks++;
    if (ovfCount !== 8'd0 || sticky !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear count=%0d sticky=%b exp 0/0", ovfCount, sticky);
    end
    driveFlags(0, 0, 1, 0);
    tick;
    checks++;
    if (ovfCount !== 8'd0 || sticky !== 1'b0) begin
      errors++;
      $display("FAIL ovf_no_setcode count=%0d sticky=%b exp 0/0", ovfCount, sticky);
    end
    setCode = 1'b1;
    repeat (10) tick;
    checks++;
    if (ovfCount !== 8'd10 || sticky !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count10 count=%0d sticky=%b exp 10/1", ovfCount, sticky);
    end
    repeat (250) tick;
    checks++;
    if (ovfCount !== 8'd255 || sticky !== 1'b1) begin
      errors++;
      $display("FAIL ovf_saturate count=%0d sticky=%b exp 255/1", ovfCount, sticky);
    end
    ovfClear = 1'b1;
    tick;
    ovfClear = 1'b0;
    checks++;
    if (ovfCount !== 8'd0 || sticky !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins count=%0d sticky=%b exp 0/0", ovfCount, sticky);
    end
    tick;
    setCode = 1'b0;
    modelFlags = 4'b0010;
    checks++;
    if (ovfCount !== 8'd1 || sticky !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_clear count=%0d sticky=%b exp 1/1", ovfCount, sticky);
    end
  endtask

  task automatic test_reset_mid_request;
    setFlags(0, 1, 0, 0);
    issue(4'h1);
    tick;
    checks++;
    if (respValid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_resp got=%b exp=1", respValid);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (respValid !== 1'b0 || reqReady !== 1'b1 || flags !== 4'b0000 || ovfCount !== 8'd0) begin
      errors++;
      $display("FAIL async_reset respValid=%b reqReady=%b flags=%b count=%0d exp 0/1/0000/0",
               respValid, reqReady, flags, ovfCount);
    end
    expQ.delete();
    modelFlags = 4'b0000;
    #2 rstN = 1'b1;
    tick;
    setFlags(0, 1, 0, 0);
    branch(4'h1);
  endtask

  initial begin
    test_reset;
    test_zero_branch;
    test_signed_compare;
    test_same_cycle_setcode;
    test_stall;
    test_all_conditions;
    test_saturation;
    test_reset_mid_request;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
